// File: rtl/led_pwm_ctrl.sv
// rtl/led_pwm_ctrl.sv - multi-channel LED PWM controller with boundary-synchronised config writes
module led_pwm_ctrl #(
    parameter int                  CHANNELS    = 3,
    parameter int                  WIDTH       = 8,
    parameter int                  PRESC_DIV   = 47,
    parameter int                  RATE_W      = 8,
    parameter logic [CHANNELS-1:0] RST_ON_MASK = 3'b100,
    localparam int                 CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [CW-1:0]       cfg_chan_i,
    input  logic [1:0]          cfg_mode_i,
    input  logic [WIDTH-1:0]    cfg_level_i,
    input  logic [RATE_W-1:0]   cfg_rate_i,
    output logic                cfg_err_o,
    output logic                period_start_o,
    output logic [CHANNELS-1:0] pwm_o
);

    localparam int PW = (PRESC_DIV > 0) ? $clog2(PRESC_DIV + 1) : 1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    logic [PW-1:0]       presc_q, presc_d;
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic                tick, boundary;
    logic                period_start_q;
    logic                cfg_err_q, cfg_err_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;

    logic                pend_q, pend_d;
    logic [CW-1:0]       stg_chan_q, stg_chan_d;
    mode_e               stg_mode_q, stg_mode_d;
    logic [WIDTH-1:0]    stg_level_q, stg_level_d;
    logic [RATE_W-1:0]   stg_rate_q, stg_rate_d;

    mode_e               mode_q   [CHANNELS];
    mode_e               mode_d   [CHANNELS];
    logic [WIDTH-1:0]    level_q  [CHANNELS];
    logic [WIDTH-1:0]    level_d  [CHANNELS];
    logic [RATE_W-1:0]   rate_q   [CHANNELS];
    logic [RATE_W-1:0]   rate_d   [CHANNELS];
    logic [RATE_W-1:0]   pcount_q [CHANNELS];
    logic [RATE_W-1:0]   pcount_d [CHANNELS];
    logic [WIDTH-1:0]    eff_q    [CHANNELS];
    logic [WIDTH-1:0]    eff_d    [CHANNELS];
    logic [WIDTH-1:0]    duty     [CHANNELS];
    logic [CHANNELS-1:0] phase_q, phase_d;
    logic [CHANNELS-1:0] dir_q, dir_d;

    logic accept;
    logic chan_bad;

    assign tick     = (presc_q == PW'(PRESC_DIV));
    assign boundary = tick && (cnt_q == {WIDTH{1'b1}});

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        cnt_d   = tick ? cnt_q + WIDTH'(1) : cnt_q;
    end

    assign cfg_ready_o = ~pend_q;
    assign accept      = cfg_valid_i && cfg_ready_o;
    assign chan_bad    = 32'(cfg_chan_i) >= 32'(CHANNELS);

    // Accept and apply never coincide: accept needs pend_q low, apply needs it high.
    always_comb begin
        pend_d      = pend_q;
        stg_chan_d  = stg_chan_q;
        stg_mode_d  = stg_mode_q;
        stg_level_d = stg_level_q;
        stg_rate_d  = stg_rate_q;
        cfg_err_d   = 1'b0;
        if (pend_q && boundary) begin
            pend_d = 1'b0;
        end
        if (accept) begin
            if (chan_bad) begin
                cfg_err_d = 1'b1;
            end else begin
                pend_d      = 1'b1;
                stg_chan_d  = cfg_chan_i;
                stg_mode_d  = mode_e'(cfg_mode_i);
                stg_level_d = cfg_level_i;
                stg_rate_d  = cfg_rate_i;
            end
        end
    end

    // dir: 0 = rising, 1 = falling
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            mode_d[i]   = mode_q[i];
            level_d[i]  = level_q[i];
            rate_d[i]   = rate_q[i];
            pcount_d[i] = pcount_q[i];
            eff_d[i]    = eff_q[i];
            phase_d[i]  = phase_q[i];
            dir_d[i]    = dir_q[i];

            case (mode_q[i])
                MODE_STATIC:  duty[i] = level_q[i];
                MODE_BLINK:   duty[i] = phase_q[i] ? level_q[i] : '0;
                MODE_BREATHE: duty[i] = eff_q[i];
                default:      duty[i] = '0;
            endcase
            pwm_d[i] = (duty[i] == {WIDTH{1'b1}}) || (cnt_q < duty[i]);

            if (boundary) begin
                if (pend_q && (stg_chan_q == CW'(i))) begin
                    mode_d[i]   = stg_mode_q;
                    level_d[i]  = stg_level_q;
                    rate_d[i]   = stg_rate_q;
                    pcount_d[i] = '0;
                    phase_d[i]  = 1'b1;
                    eff_d[i]    = '0;
                    dir_d[i]    = 1'b0;
                end else if (pcount_q[i] == rate_q[i]) begin
                    pcount_d[i] = '0;
                    phase_d[i]  = ~phase_q[i];
                    if (mode_q[i] == MODE_BREATHE) begin
                        if (level_q[i] == '0) begin
                            eff_d[i] = '0;
                            dir_d[i] = 1'b0;
                        end else if (eff_q[i] > level_q[i]) begin
                            eff_d[i] = level_q[i];
                            dir_d[i] = 1'b1;
                        end else if (!dir_q[i]) begin
                            if (eff_q[i] == level_q[i]) begin
                                eff_d[i] = eff_q[i] - WIDTH'(1);
                                dir_d[i] = 1'b1;
                            end else begin
                                eff_d[i] = eff_q[i] + WIDTH'(1);
                                dir_d[i] = ((eff_q[i] + WIDTH'(1)) == level_q[i]);
                            end
                        end else begin
                            if (eff_q[i] == '0) begin
                                eff_d[i] = WIDTH'(1);
                                dir_d[i] = 1'b0;
                            end else begin
                                eff_d[i] = eff_q[i] - WIDTH'(1);
                                dir_d[i] = (eff_q[i] != WIDTH'(1));
                            end
                        end
                    end
                end else begin
                    pcount_d[i] = pcount_q[i] + RATE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            presc_q        <= '0;
            cnt_q          <= '0;
            period_start_q <= 1'b0;
            cfg_err_q      <= 1'b0;
            pwm_q          <= '0;
            pend_q         <= 1'b0;
            stg_chan_q     <= '0;
            stg_mode_q     <= MODE_OFF;
            stg_level_q    <= '0;
            stg_rate_q     <= '0;
            phase_q        <= '1;
            dir_q          <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= RST_ON_MASK[i] ? MODE_STATIC : MODE_OFF;
                level_q[i]  <= {WIDTH{RST_ON_MASK[i]}};
                rate_q[i]   <= '0;
                pcount_q[i] <= '0;
                eff_q[i]    <= '0;
            end
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            period_start_q <= boundary;
            cfg_err_q      <= cfg_err_d;
            pwm_q          <= pwm_d;
            pend_q         <= pend_d;
            stg_chan_q     <= stg_chan_d;
            stg_mode_q     <= stg_mode_d;
            stg_level_q    <= stg_level_d;
            stg_rate_q     <= stg_rate_d;
            phase_q        <= phase_d;
            dir_q          <= dir_d;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]   <= mode_d[i];
                level_q[i]  <= level_d[i];
                rate_q[i]   <= rate_d[i];
                pcount_q[i] <= pcount_d[i];
                eff_q[i]    <= eff_d[i];
            end
        end
    end

    assign cfg_err_o      = cfg_err_q;
    assign period_start_o = period_start_q;
    assign pwm_o          = pwm_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// tb/tb_led_pwm_ctrl.sv - self-checking bench for led_pwm_ctrl against a period-level reference model
module tb_led_pwm_ctrl;

    localparam int CH  = 3;
    localparam int W   = 4;
    localparam int PER = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [1:0]   cfg_chan = '0;
    logic [1:0]   cfg_mode = '0;
    logic [W-1:0] cfg_level = '0;
    logic [7:0]   cfg_rate = '0;
    logic         cfg_err;
    logic         period_start;
    logic [CH-1:0] pwm;

    always #5 clk = ~clk;

    led_pwm_ctrl #(
        .CHANNELS(CH), .WIDTH(W), .PRESC_DIV(0), .RATE_W(8), .RST_ON_MASK(3'b100)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_chan_i(cfg_chan), .cfg_mode_i(cfg_mode),
        .cfg_level_i(cfg_level), .cfg_rate_i(cfg_rate),
        .cfg_err_o(cfg_err), .period_start_o(period_start), .pwm_o(pwm)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Active configuration per channel and the period index it took effect in
    int m_mode[CH], m_level[CH], m_rate[CH], m_start[CH];
    bit pend_v;
    int p_chan, p_mode, p_level, p_rate, p_period;
    bit last_acc;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_mode[i]  = (i == 2) ? 1 : 0;
            m_level[i] = (i == 2) ? PER - 1 : 0;
            m_rate[i]  = 0;
            m_start[i] = 0;
        end
        pend_v = 1'b0;
    endtask

    function automatic int duty(input int ch, input int p);
        int k, st, pos, lv;
        k  = p - m_start[ch];
        lv = m_level[ch];
        st = k / (m_rate[ch] + 1);
        case (m_mode[ch])
            0: return 0;
            1: return lv;
            2: return (st % 2 == 0) ? lv : 0;
            default: begin
                if (lv == 0) return 0;
                pos = st % (2 * lv);
                return (pos <= lv) ? pos : 2 * lv - pos;
            end
        endcase
    endfunction

    function automatic bit exp_ready();
        return !(pend_v && cyc < p_period * PER);
    endfunction

    task automatic tick();
        bit acc, err_exp;
        int p, cp, d;
        logic [CH-1:0] pe;
        if (pend_v && cyc >= p_period * PER) begin
            m_mode[p_chan]  = p_mode;
            m_level[p_chan] = p_level;
            m_rate[p_chan]  = p_rate;
            m_start[p_chan] = p_period;
            pend_v = 1'b0;
        end
        acc = cfg_valid && exp_ready();
        err_exp = 1'b0;
        if (acc) begin
            if (int'(cfg_chan) >= CH) begin
                err_exp = 1'b1;
            end else begin
                pend_v   = 1'b1;
                p_chan   = int'(cfg_chan);
                p_mode   = int'(cfg_mode);
                p_level  = int'(cfg_level);
                p_rate   = int'(cfg_rate);
                p_period = (cyc + 1) / PER + 1;
            end
        end
        last_acc = acc;
        @(posedge clk);
        cyc++;
        #1;
        p  = (cyc - 1) / PER;
        cp = (cyc - 1) % PER;
        for (int i = 0; i < CH; i++) begin
            d = duty(i, p);
            pe[i] = (d == PER - 1) || (cp < d);
        end
        chk("pwm", 8'(pwm), 8'(pe));
        chk("period_start", 8'(period_start), 8'(cyc >= PER && cyc % PER == 0));
        chk("cfg_ready", 8'(cfg_ready), 8'(exp_ready()));
        chk("cfg_err", 8'(cfg_err), 8'(err_exp));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_write(input int ch, input int mode, input int lvl, input int rate, output int acc_cyc);
        bit ok;
        ok = 1'b0;
        acc_cyc = cyc;
        cfg_valid = 1'b1;
        cfg_chan  = 2'(ch);
        cfg_mode  = 2'(mode);
        cfg_level = W'(lvl);
        cfg_rate  = 8'(rate);
        for (int n = 0; n < 64 && !ok; n++) begin
            acc_cyc = cyc;
            tick();
            ok = last_acc;
        end
        cfg_valid = 1'b0;
        chk("write_accept", 8'(ok), 8'd1);
    endtask

    task automatic align_to_period(input int acc_cyc);
        int ap;
        ap = (acc_cyc + 1) / PER + 1;
        for (int n = 0; n < 4 * PER && cyc < ap * PER; n++) tick();
    endtask

    task automatic count_period(input int ch, output int hi);
        hi = 0;
        for (int n = 0; n < PER; n++) begin
            tick();
            hi += int'(pwm[ch]);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_pwm"}, 8'(pwm), 8'd0);
        chk({tag, "_period_start"}, 8'(period_start), 8'd0);
        chk({tag, "_cfg_err"}, 8'(cfg_err), 8'd0);
        chk({tag, "_cfg_ready"}, 8'(cfg_ready), 8'd1);
    endtask

    int ac, hi;
    int blink_exp[4]   = '{16, 16, 0, 0};
    int breathe_exp[8] = '{0, 1, 2, 3, 2, 1, 0, 1};

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst_n = 1'b1;
        cyc = 0;

        // Reset pattern and period_start cadence
        run(40);

        // Static level 4 on channel 0, written mid-period
        while (cyc % PER != 5) tick();
        do_write(0, 1, 4, 0, ac);
        align_to_period(ac);
        count_period(0, hi);
        chk("static_hightime", 8'(hi), 8'd4);
        run(PER);

        // Blink full level, rate 1
        do_write(1, 2, 15, 1, ac);
        align_to_period(ac);
        for (int p = 0; p < 4; p++) begin
            count_period(1, hi);
            chk("blink_hightime", 8'(hi), 8'(blink_exp[p]));
        end

        // Breathe peak 3, rate 0
        do_write(2, 3, 3, 0, ac);
        align_to_period(ac);
        for (int p = 0; p < 8; p++) begin
            count_period(2, hi);
            chk("breathe_hightime", 8'(hi), 8'(breathe_exp[p]));
        end

        // Write to a nonexistent channel
        do_write(3, 1, 7, 0, ac);
        run(2 * PER);

        // Accept on the boundary cycle, then reset before it could apply
        while (cyc % PER != PER - 1) tick();
        do_write(0, 1, 9, 0, ac);
        chk("accept_on_boundary", 8'(ac % PER), 8'(PER - 1));
        run(6);
        rst_n = 1'b0;
        #1;
        check_reset_outs("midreset");
        @(posedge clk);
        #1;
        check_reset_outs("held_reset");
        model_reset();
        rst_n = 1'b1;
        cyc = 0;
        run(3 * PER);

        // Randomised writes, including invalid channels
        for (int n = 0; n < 24; n++) begin
            do_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), ac);
            run(int'($urandom_range(0, 40)));
        end
        run(4 * PER);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
- Parametrised multi-channel LED PWM controller. Its outputs drive the RGBxPWM inputs of the SB_RGBA_DRV hard IP in the board top, replacing constant LED tie-offs.
- Each channel has its own duty level, mode (off / static / blink / breathe) and rate.
- Configuration arrives over a valid/ready write port. Writes are staged and applied only at a PWM period boundary, so the LEDs never glitch.

Parameters:
- CHANNELS, 3: number of PWM channels (RGB0=G, RGB1=B, RGB2=R on the board).
- WIDTH, 8: PWM counter and level width. Period is 2^WIDTH ticks.
- PRESC_DIV, 47: the PWM counter advances once every PRESC_DIV+1 clocks.
- RATE_W, 8: width of the per-channel rate field.
- RST_ON_MASK, 3'b100: channels set in this mask reset to STATIC at full level; all others reset to OFF.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- cfg_valid, in, 1: config write request.
- cfg_ready, out, 1: config write can be accepted.
- cfg_chan, in, $clog2(CHANNELS) (min 1): target channel.
- cfg_mode, in, 2: 0=OFF, 1=STATIC, 2=BLINK, 3=BREATHE.
- cfg_level, in, WIDTH: duty level (peak level for BREATHE).
- cfg_rate, in, RATE_W: blink/breathe step interval, in PWM periods minus 1.
- cfg_err, out, 1: one-cycle pulse when an accepted write targets cfg_chan >= CHANNELS.
- period_start, out, 1: one-cycle pulse on the first clock of each PWM period.
- pwm, out, CHANNELS: registered PWM outputs to SB_RGBA_DRV.

Behaviour:
- Reset values (async, immediate):
  - pwm=0, period_start=0, cfg_err=0, cfg_ready=1.
  - presc=0, cnt=0, no write pending.
  - Per channel: rate=0, phase=on, eff=0, dir=up, pcount=0.
  - Mask channels: mode=STATIC, level=all-ones. Other channels: mode=OFF, level=0.
  - Mask channels drive pwm=1 from the first clock edge after rst_n deasserts.
- Timebase:
  - tick when presc==PRESC_DIV; presc then wraps to 0, otherwise increments.
  - cnt increments on tick.
  - boundary = tick && cnt==2^WIDTH-1. cnt wraps to 0 on boundary.
  - period_start is registered and asserts in the cycle cnt reads 0 after a wrap. It is not asserted out of reset.
- Duty compare: pwm[i] <= (duty_i == all-ones) | (cnt < duty_i). Level all-ones gives constant high; level 0 gives constant low.
- Per-mode duty_i:
  - OFF: 0.
  - STATIC: level.
  - BLINK: level when phase=on, else 0.
    - pcount counts boundaries. When pcount==rate: phase toggles and pcount=0.
    - rate=0 toggles every period.
  - BREATHE: duty_i = eff, which forms a triangle wave.
    - Every rate+1 boundaries: if dir=up, eff++; when eff reaches level, dir=down. If dir=down, eff--; when eff reaches 0, dir=up.
    - level=0 holds eff at 0.
    - If level is lowered below eff, eff clamps to level and dir=down.
- Config handshake:
  - A write is accepted on cfg_valid && cfg_ready. Fields are captured into a one-deep stage and cfg_ready drops the next cycle.
  - On the next boundary, the stage is applied and cfg_ready rises the following cycle.
  - An accept in the same cycle as a boundary is applied at the following boundary, not the current one.
  - Applying a write resets that channel's pcount=0, phase=on, eff=0, dir=up.
  - Invalid channel: the write is accepted, cfg_err pulses the cycle after accept, nothing is staged, and cfg_ready stays 1.
  - cfg_valid while cfg_ready=0 has no effect. The master must hold the request until it is accepted.
- Unwritten channels keep running undisturbed across other channels' updates.
- rst_n asserted mid-period or with a write pending: the pending write is discarded and all state returns to reset values immediately.

Test Plan:
1. WIDTH=4, PRESC_DIV=0, default mask; release reset → pwm=3'b100 from cycle 1; period_start first pulses at clk 16, then every 16 clocks.
2. Write chan0 STATIC level=4 mid-period → cfg_ready low until the boundary; pwm[0] is high exactly 4 of 16 clocks starting in the next period, and was 0 before it.
3. Write chan1 BLINK level=15 rate=1 → pwm[1] high for 2 periods (32 clk), then low for 2 periods, repeating.
4. Write chan2 BREATHE level=3 rate=0 → eff sequence per period: 0,1,2,3,2,1,0,1…; high-time per period matches eff.
5. Write with cfg_chan=3 (CHANNELS=3) → cfg_err pulses once, cfg_ready never drops, all pwm patterns unchanged.
6. Accept a write on the exact boundary cycle, then assert rst_n low mid-next-period → the write is not applied at that boundary; after reset, outputs return to 3'b100 and no stale write is applied.
